// File: rtl/agex_stage_pkg.sv
// Shared types, opcodes and widths for the address-generate/execute stage.
package agex_stage_pkg;

    localparam int unsigned DBITS      = 32;
    localparam int unsigned MUL_STEPS  = 32;
    localparam int unsigned REG_BITS   = 5;
    localparam int unsigned OP_BITS    = 6;
    localparam int unsigned SHAMT_BITS = $clog2(DBITS);

    // Decoded operation carried in op_i
    typedef enum logic [OP_BITS-1:0] {
        OP_INVALID = 6'd0,
        OP_ADD     = 6'd1,
        OP_SUB     = 6'd2,
        OP_AND     = 6'd3,
        OP_OR      = 6'd4,
        OP_XOR     = 6'd5,
        OP_SLT     = 6'd6,
        OP_SLTU    = 6'd7,
        OP_SLL     = 6'd8,
        OP_SRL     = 6'd9,
        OP_SRA     = 6'd10,
        OP_ADDI    = 6'd11,
        OP_ANDI    = 6'd12,
        OP_ORI     = 6'd13,
        OP_XORI    = 6'd14,
        OP_SLTI    = 6'd15,
        OP_SLTIU   = 6'd16,
        OP_SLLI    = 6'd17,
        OP_SRLI    = 6'd18,
        OP_SRAI    = 6'd19,
        OP_LUI     = 6'd20,
        OP_AUIPC   = 6'd21,
        OP_JAL     = 6'd22,
        OP_JALR    = 6'd23,
        OP_BEQ     = 6'd24,
        OP_BNE     = 6'd25,
        OP_BLT     = 6'd26,
        OP_BGE     = 6'd27,
        OP_BLTU    = 6'd28,
        OP_BGEU    = 6'd29,
        OP_LW      = 6'd30,
        OP_SW      = 6'd31,
        OP_MUL     = 6'd32
    } op_e;

    // Decode latch as seen by this stage
    typedef struct packed {
        logic                valid;
        logic [DBITS-1:0]    inst;
        logic [DBITS-1:0]    pc;
        op_e                 op_i;
        logic [DBITS-1:0]    inst_count;
        logic [DBITS-1:0]    rs1_val;
        logic [DBITS-1:0]    rs2_val;
        logic [DBITS-1:0]    imm;
        logic [REG_BITS-1:0] rd;
        logic                wr_reg;
        logic [DBITS-1:0]    bus_canary;
    } de_latch_t;

    // AGEX latch unpacked by the memory stage
    typedef struct packed {
        logic [DBITS-1:0]    inst;
        logic [DBITS-1:0]    pc;
        op_e                 op_i;
        logic [DBITS-1:0]    inst_count;
        logic [DBITS-1:0]    aluout;
        logic [REG_BITS-1:0] rd;
        logic                wr_reg;
        logic [DBITS-1:0]    memaddr;
        logic [DBITS-1:0]    wr_val;
        logic                wr_mem;
        logic [DBITS-1:0]    bus_canary;
    } agex_latch_t;

    // Fetch redirect
    typedef struct packed {
        logic             br_mispred;
        logic [DBITS-1:0] br_target;
    } agex_to_fe_t;

    // Decode control
    typedef struct packed {
        logic agex_busy;
        logic br_mispred;
    } agex_to_de_t;

    localparam int unsigned DE_LATCH_WIDTH        = $bits(de_latch_t);
    localparam int unsigned AGEX_LATCH_WIDTH      = $bits(agex_latch_t);
    localparam int unsigned FROM_AGEX_TO_FE_WIDTH = $bits(agex_to_fe_t);
    localparam int unsigned FROM_AGEX_TO_DE_WIDTH = $bits(agex_to_de_t);

    function automatic logic is_branch(input op_e op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) ||
               (op == OP_BGE) || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

    function automatic logic is_imm_op(input op_e op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_XORI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
               (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
    endfunction

endpackage

// File: rtl/agex_stage_if.sv
// Pipeline buses between decode, AGEX, fetch and memory.
interface agex_stage_if;
    import agex_stage_pkg::*;

    de_latch_t   from_DE_latch;
    agex_latch_t AGEX_latch_out;
    agex_to_fe_t from_AGEX_to_FE;
    agex_to_de_t from_AGEX_to_DE;

    modport master (
        output from_DE_latch,
        input  AGEX_latch_out,
        input  from_AGEX_to_FE,
        input  from_AGEX_to_DE
    );

    modport slave (
        input  from_DE_latch,
        output AGEX_latch_out,
        output from_AGEX_to_FE,
        output from_AGEX_to_DE
    );
endinterface

// File: rtl/agex_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
module agex_mul_iter
    import agex_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DBITS,
    parameter int unsigned STEPS = MUL_STEPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             busy,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c
);
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next_c;

    // Accumulator value after the current step
    always_comb begin
        acc_next_c = acc;
        if (mplier[0]) begin
            acc_next_c = acc + mcand;
        end
    end

    assign busy     = (state == S_BUSY);
    assign done_c   = (state == S_BUSY) && (cnt == CNT_W'(STEPS - 1));
    assign result_c = acc_next_c;

    // Control FSM and shift/accumulate datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= mcand_in;
                        mplier <= mplier_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next_c;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (done_c) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/agex_stage.sv
// AGEX stage: ALU, branch resolution, address generation and multiply sequencing.
module agex_stage
    import agex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    agex_stage_if.slave  bus
);
    de_latch_t        de;
    agex_latch_t      latch;
    agex_latch_t      hold;
    agex_latch_t      fields_c;
    agex_latch_t      latch_next_c;
    logic [DBITS-1:0] op_b_c;
    logic [SHAMT_BITS-1:0] sh_c;
    logic [DBITS-1:0] alu_c;
    logic [DBITS-1:0] target_c;
    logic             taken_c;
    logic             idle_c;
    logic             start_c;
    logic             mispred_c;
    logic             busy_c;
    logic             mul_busy;
    logic             mul_done_c;
    logic [DBITS-1:0] mul_result_c;

    assign de = bus.from_DE_latch;

    agex_mul_iter #(
        .WIDTH (DBITS),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (start_c),
        .mcand_in  (de.rs1_val),
        .mplier_in (de.rs2_val),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .result_c  (mul_result_c)
    );

    // Second ALU operand and shift amount
    always_comb begin
        op_b_c = de.rs2_val;
        if (is_imm_op(de.op_i)) begin
            op_b_c = de.imm;
        end
        sh_c = op_b_c[SHAMT_BITS-1:0];
    end

    // Branch comparison
    always_comb begin
        taken_c = 1'b0;
        case (de.op_i)
            OP_BEQ:  taken_c = (de.rs1_val == de.rs2_val);
            OP_BNE:  taken_c = (de.rs1_val != de.rs2_val);
            OP_BLT:  taken_c = ($signed(de.rs1_val) <  $signed(de.rs2_val));
            OP_BGE:  taken_c = ($signed(de.rs1_val) >= $signed(de.rs2_val));
            OP_BLTU: taken_c = (de.rs1_val <  de.rs2_val);
            OP_BGEU: taken_c = (de.rs1_val >= de.rs2_val);
            default: taken_c = 1'b0;
        endcase
    end

    // ALU result; branches record their compare outcome
    always_comb begin
        alu_c = '0;
        case (de.op_i)
            OP_ADD, OP_ADDI:   alu_c = de.rs1_val + op_b_c;
            OP_SUB:            alu_c = de.rs1_val - op_b_c;
            OP_AND, OP_ANDI:   alu_c = de.rs1_val & op_b_c;
            OP_OR, OP_ORI:     alu_c = de.rs1_val | op_b_c;
            OP_XOR, OP_XORI:   alu_c = de.rs1_val ^ op_b_c;
            OP_SLT, OP_SLTI:   alu_c = DBITS'($signed(de.rs1_val) < $signed(op_b_c));
            OP_SLTU, OP_SLTIU: alu_c = DBITS'(de.rs1_val < op_b_c);
            OP_SLL, OP_SLLI:   alu_c = de.rs1_val << sh_c;
            OP_SRL, OP_SRLI:   alu_c = de.rs1_val >> sh_c;
            OP_SRA, OP_SRAI:   alu_c = $signed(de.rs1_val) >>> sh_c;
            OP_LUI:            alu_c = de.imm;
            OP_AUIPC:          alu_c = de.pc + de.imm;
            OP_JAL, OP_JALR:   alu_c = de.pc + DBITS'(4);
            OP_LW, OP_SW:      alu_c = de.rs1_val + de.imm;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                               alu_c = DBITS'(taken_c);
            default:           alu_c = '0;
        endcase
    end

    // Jump/branch target; JALR clears bit 0
    always_comb begin
        target_c = de.pc + de.imm;
        if (de.op_i == OP_JALR) begin
            target_c = (de.rs1_val + de.imm) & ~DBITS'(1);
        end
    end

    // Redirect and stall decisions, only meaningful while idle
    always_comb begin
        idle_c    = !mul_busy;
        start_c   = idle_c && de.valid && (de.op_i == OP_MUL);
        mispred_c = idle_c && de.valid &&
                    ((de.op_i == OP_JAL) || (de.op_i == OP_JALR) ||
                     (is_branch(de.op_i) && taken_c));
        busy_c    = start_c || (mul_busy && !mul_done_c);
    end

    // Latch payload built from the current decode entry
    always_comb begin
        fields_c            = '0;
        fields_c.inst       = de.inst;
        fields_c.pc         = de.pc;
        fields_c.op_i       = de.op_i;
        fields_c.inst_count = de.inst_count;
        fields_c.aluout     = alu_c;
        fields_c.rd         = de.rd;
        fields_c.wr_reg     = de.wr_reg && !is_branch(de.op_i) && (de.op_i != OP_SW);
        fields_c.memaddr    = alu_c;
        fields_c.wr_val     = de.rs2_val;
        fields_c.wr_mem     = (de.op_i == OP_SW);
        fields_c.bus_canary = de.bus_canary;
    end

    // Next latch contents: multiply completion, normal op, or bubble
    always_comb begin
        latch_next_c = '0;
        if (mul_done_c) begin
            latch_next_c         = hold;
            latch_next_c.aluout  = mul_result_c;
            latch_next_c.memaddr = mul_result_c;
        end else if (idle_c && de.valid && !start_c) begin
            latch_next_c = fields_c;
        end
    end

    // AGEX latch and captured multiply context
    always_ff @(posedge clk) begin
        if (reset) begin
            latch <= '0;
            hold  <= '0;
        end else begin
            latch <= latch_next_c;
            if (start_c) begin
                hold <= fields_c;
            end
        end
    end

    // Output buses
    always_comb begin
        bus.AGEX_latch_out             = latch;
        bus.from_AGEX_to_FE            = '0;
        bus.from_AGEX_to_FE.br_mispred = mispred_c;
        bus.from_AGEX_to_FE.br_target  = target_c;
        bus.from_AGEX_to_DE            = '0;
        bus.from_AGEX_to_DE.agex_busy  = busy_c;
        bus.from_AGEX_to_DE.br_mispred = mispred_c;
    end

endmodule

// File: tb/tb_agex_stage.sv
// Randomized and directed bench for agex_stage against a behavioural RV32I model.
module tb_agex_stage;
    import agex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    agex_stage_if bus();

    agex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One pipeline cycle: drive just after the edge, leave us at the following negedge
    task automatic step(input de_latch_t d, input logic r);
        @(posedge clk);
        #1;
        reset = r;
        bus.from_DE_latch = d;
        @(negedge clk);
    endtask

    function automatic de_latch_t mk(input op_e op, input logic [31:0] pc, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
        de_latch_t d;
        d            = '0;
        d.valid      = 1'b1;
        d.inst       = $urandom;
        d.pc         = pc;
        d.op_i       = op;
        d.inst_count = $urandom;
        d.rs1_val    = a;
        d.rs2_val    = b;
        d.imm        = imm;
        d.rd         = rd;
        d.wr_reg     = 1'b1;
        d.bus_canary = $urandom;
        return d;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 40));
            2:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            default: v = 32'h8000_0000 + 32'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    function automatic logic ref_is_branch(input op_e op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic ref_is_jump(input op_e op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic ref_taken(input de_latch_t d);
        int sa, sb;
        sa = int'(d.rs1_val);
        sb = int'(d.rs2_val);
        case (d.op_i)
            OP_BEQ:  return d.rs1_val == d.rs2_val;
            OP_BNE:  return d.rs1_val != d.rs2_val;
            OP_BLT:  return sa < sb;
            OP_BGE:  return !(sa < sb);
            OP_BLTU: return d.rs1_val < d.rs2_val;
            OP_BGEU: return !(d.rs1_val < d.rs2_val);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input de_latch_t d);
        if (d.op_i == OP_JALR) return (d.rs1_val + d.imm) & 32'hFFFF_FFFE;
        return d.pc + d.imm;
    endfunction

    function automatic logic [31:0] ref_alu(input de_latch_t d);
        logic [31:0] a, b, r;
        logic [63:0] ext;
        int unsigned sh;
        a = d.rs1_val;
        b = (d.op_i >= OP_ADDI && d.op_i <= OP_SRAI) ? d.imm : d.rs2_val;
        sh = int'(b & 32'h1F);
        r = '0;
        case (d.op_i)
            OP_ADD, OP_ADDI:   r = a + b;
            OP_SUB:            r = a - b;
            OP_AND, OP_ANDI:   r = a & b;
            OP_OR, OP_ORI:     r = a | b;
            OP_XOR, OP_XORI:   r = a ^ b;
            OP_SLT, OP_SLTI:   r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU: r = (a < b) ? 32'd1 : 32'd0;
            OP_SLL, OP_SLLI:   r = a << sh;
            OP_SRL, OP_SRLI:   r = a >> sh;
            OP_SRA, OP_SRAI: begin
                ext = {{32{a[31]}}, a};
                ext = ext >> sh;
                r   = ext[31:0];
            end
            OP_LUI:            r = d.imm;
            OP_AUIPC:          r = d.pc + d.imm;
            OP_JAL, OP_JALR:   r = d.pc + 32'd4;
            OP_LW, OP_SW:      r = a + d.imm;
            default:           r = '0;
        endcase
        return r;
    endfunction

    // Expected latch, with fields the model leaves unspecified zeroed
    function automatic agex_latch_t exp_latch(input de_latch_t d);
        agex_latch_t e;
        logic mem;
        e = '0;
        if (!d.valid) return e;
        mem          = (d.op_i == OP_LW) || (d.op_i == OP_SW);
        e.inst       = d.inst;
        e.pc         = d.pc;
        e.op_i       = d.op_i;
        e.inst_count = d.inst_count;
        e.aluout     = ref_is_branch(d.op_i) ? 32'd0 : ref_alu(d);
        e.rd         = d.rd;
        e.wr_reg     = (ref_is_branch(d.op_i) || d.op_i == OP_SW) ? 1'b0 : d.wr_reg;
        e.memaddr    = mem ? d.rs1_val + d.imm : 32'd0;
        e.wr_val     = mem ? d.rs2_val : 32'd0;
        e.wr_mem     = (d.op_i == OP_SW);
        e.bus_canary = d.bus_canary;
        return e;
    endfunction

    function automatic agex_latch_t mask(input agex_latch_t l, input op_e op);
        agex_latch_t m;
        m = l;
        if (op != OP_LW && op != OP_SW) begin
            m.memaddr = '0;
            m.wr_val  = '0;
        end
        if (ref_is_branch(op)) m.aluout = '0;
        return m;
    endfunction

    task automatic test_reset();
        step('0, 1'b1);
        step(mk(OP_JAL, 32'h40, 0, 0, 32'h10, 5'd1), 1'b1);
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out !== '0) begin
            bad++; $display("FAIL reset_latch got=%h want=0", bus.AGEX_latch_out);
        end
        total++;
        if (bus.from_AGEX_to_FE.br_mispred !== 1'b0 || bus.from_AGEX_to_DE.br_mispred !== 1'b0) begin
            bad++; $display("FAIL reset_mispred got=%b/%b want=0", bus.from_AGEX_to_FE.br_mispred,
                            bus.from_AGEX_to_DE.br_mispred);
        end
        total++;
        if (bus.from_AGEX_to_DE.agex_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", bus.from_AGEX_to_DE.agex_busy);
        end
    endtask

    task automatic test_add();
        step(mk(OP_ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3), 1'b0);
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out.aluout !== 32'd12 || bus.AGEX_latch_out.rd !== 5'd3 ||
            bus.AGEX_latch_out.wr_reg !== 1'b1 || bus.AGEX_latch_out.wr_mem !== 1'b0) begin
            bad++; $display("FAIL add got alu=%h rd=%0d wr_reg=%b wr_mem=%b want 0000000c/3/1/0",
                            bus.AGEX_latch_out.aluout, bus.AGEX_latch_out.rd,
                            bus.AGEX_latch_out.wr_reg, bus.AGEX_latch_out.wr_mem);
        end
    endtask

    task automatic test_branch();
        step(mk(OP_BEQ, 32'h100, 32'd9, 32'd9, 32'h20, 5'd4), 1'b0);
        total++;
        if (bus.from_AGEX_to_FE.br_mispred !== 1'b1 || bus.from_AGEX_to_DE.br_mispred !== 1'b1 ||
            bus.from_AGEX_to_FE.br_target !== 32'h120) begin
            bad++; $display("FAIL beq_taken got mis=%b/%b tgt=%h want 1/1/00000120",
                            bus.from_AGEX_to_FE.br_mispred, bus.from_AGEX_to_DE.br_mispred,
                            bus.from_AGEX_to_FE.br_target);
        end
        step(mk(OP_BEQ, 32'h100, 32'd9, 32'd8, 32'h20, 5'd4), 1'b0);
        total++;
        if (bus.AGEX_latch_out.wr_reg !== 1'b0 || bus.AGEX_latch_out.pc !== 32'h100) begin
            bad++; $display("FAIL beq_latch got wr_reg=%b pc=%h want 0/00000100",
                            bus.AGEX_latch_out.wr_reg, bus.AGEX_latch_out.pc);
        end
        total++;
        if (bus.from_AGEX_to_FE.br_mispred !== 1'b0 || bus.from_AGEX_to_DE.br_mispred !== 1'b0) begin
            bad++; $display("FAIL beq_not_taken got mis=%b want 0", bus.from_AGEX_to_FE.br_mispred);
        end
        step('0, 1'b0);
    endtask

    task automatic test_jalr();
        step(mk(OP_JALR, 32'h200, 32'h1003, 32'd0, 32'd0, 5'd1), 1'b0);
        total++;
        if (bus.from_AGEX_to_FE.br_mispred !== 1'b1 || bus.from_AGEX_to_FE.br_target !== 32'h1002) begin
            bad++; $display("FAIL jalr_redirect got mis=%b tgt=%h want 1/00001002",
                            bus.from_AGEX_to_FE.br_mispred, bus.from_AGEX_to_FE.br_target);
        end
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out.aluout !== 32'h204 || bus.AGEX_latch_out.wr_reg !== 1'b1) begin
            bad++; $display("FAIL jalr_link got alu=%h wr_reg=%b want 00000204/1",
                            bus.AGEX_latch_out.aluout, bus.AGEX_latch_out.wr_reg);
        end
    endtask

    task automatic test_sw();
        step(mk(OP_SW, 32'h300, 32'h1000, 32'hDEAD, 32'hFFFF_FFFC, 5'd0), 1'b0);
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out.memaddr !== 32'h0FFC || bus.AGEX_latch_out.wr_val !== 32'hDEAD ||
            bus.AGEX_latch_out.wr_mem !== 1'b1 || bus.AGEX_latch_out.wr_reg !== 1'b0) begin
            bad++; $display("FAIL sw got addr=%h val=%h wr_mem=%b wr_reg=%b want 00000ffc/0000dead/1/0",
                            bus.AGEX_latch_out.memaddr, bus.AGEX_latch_out.wr_val,
                            bus.AGEX_latch_out.wr_mem, bus.AGEX_latch_out.wr_reg);
        end
    endtask

    // Back-to-back random non-MUL traffic with interleaved bubbles
    task automatic test_random_ops();
        de_latch_t   d, prev;
        agex_latch_t e, act;
        logic        exp_mis;
        prev = '0;
        step('0, 1'b0);
        for (int i = 0; i <= 150; i++) begin
            if (i == 150 || $urandom_range(0, 5) == 0) begin
                d = '0;
            end else begin
                d = mk(op_e'($urandom_range(1, 31)), $urandom & 32'hFFFF_FFFC, rand_val(), rand_val(),
                       rand_val(), 5'($urandom_range(0, 31)));
                if ($urandom_range(0, 3) == 0) d.rs2_val = d.rs1_val;
                d.wr_reg = 1'($urandom);
            end
            step(d, 1'b0);
            exp_mis = d.valid && (ref_is_jump(d.op_i) || (ref_is_branch(d.op_i) && ref_taken(d)));
            total++;
            if (bus.from_AGEX_to_FE.br_mispred !== exp_mis || bus.from_AGEX_to_DE.br_mispred !== exp_mis ||
                bus.from_AGEX_to_DE.agex_busy !== 1'b0) begin
                bad++; $display("FAIL rand_redirect[%0d] op=%0d got mis=%b busy=%b want mis=%b busy=0",
                                i, d.op_i, bus.from_AGEX_to_FE.br_mispred,
                                bus.from_AGEX_to_DE.agex_busy, exp_mis);
            end
            if (exp_mis) begin
                total++;
                if (bus.from_AGEX_to_FE.br_target !== ref_target(d)) begin
                    bad++; $display("FAIL rand_target[%0d] got=%h want=%h", i,
                                    bus.from_AGEX_to_FE.br_target, ref_target(d));
                end
            end
            e   = exp_latch(prev);
            act = mask(bus.AGEX_latch_out, e.op_i);
            total++;
            if (act !== e) begin
                bad++; $display("FAIL rand_latch[%0d] op=%0d got=%h want=%h", i, prev.op_i, act, e);
            end
            prev = d;
        end
    endtask

    // MUL with a dependent ADD held behind it by decode
    task automatic test_mul();
        de_latch_t   m, a;
        agex_latch_t e;
        m = mk(OP_MUL, 32'h500, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd6);
        a = mk(OP_ADD, 32'h504, 32'd100, 32'd23, 32'd0, 5'd7);
        step(m, 1'b0);
        total++;
        if (bus.from_AGEX_to_DE.agex_busy !== 1'b1) begin
            bad++; $display("FAIL mul_busy[0] got=0 want=1");
        end
        for (int c = 1; c <= 33; c++) begin
            step(a, 1'b0);
            total++;
            if (bus.from_AGEX_to_DE.agex_busy !== (c <= 31) || bus.from_AGEX_to_FE.br_mispred !== 1'b0) begin
                bad++; $display("FAIL mul_busy[%0d] got busy=%b mis=%b want busy=%b mis=0", c,
                                bus.from_AGEX_to_DE.agex_busy, bus.from_AGEX_to_FE.br_mispred, c <= 31);
            end
            total++;
            if (c <= 32 && bus.AGEX_latch_out !== '0) begin
                bad++; $display("FAIL mul_bubble[%0d] got=%h want=0", c, bus.AGEX_latch_out);
            end else if (c == 33 && (bus.AGEX_latch_out.aluout !== 32'hFFFF_FFFD ||
                     bus.AGEX_latch_out.rd !== 5'd6 || bus.AGEX_latch_out.inst !== m.inst ||
                     bus.AGEX_latch_out.pc !== 32'h500 || bus.AGEX_latch_out.wr_reg !== 1'b1)) begin
                bad++; $display("FAIL mul_result got alu=%h rd=%0d pc=%h want fffffffd/6/00000500",
                                bus.AGEX_latch_out.aluout, bus.AGEX_latch_out.rd, bus.AGEX_latch_out.pc);
            end
        end
        step('0, 1'b0);
        e = exp_latch(a);
        total++;
        if (mask(bus.AGEX_latch_out, OP_ADD) !== e) begin
            bad++; $display("FAIL mul_then_add got=%h want=%h", bus.AGEX_latch_out, e);
        end
    endtask

    task automatic test_mul_random();
        de_latch_t   m;
        logic [31:0] p;
        for (int k = 0; k < 4; k++) begin
            m = mk(OP_MUL, 32'h600, rand_val(), rand_val(), 32'd0, 5'($urandom_range(1, 31)));
            p = m.rs1_val * m.rs2_val;
            step(m, 1'b0);
            for (int c = 1; c <= 32; c++) step('0, 1'b0);
            step('0, 1'b0);
            total++;
            if (bus.AGEX_latch_out.aluout !== p || bus.AGEX_latch_out.rd !== m.rd ||
                bus.AGEX_latch_out.bus_canary !== m.bus_canary) begin
                bad++; $display("FAIL mul_rand[%0d] %h*%h got=%h want=%h", k, m.rs1_val, m.rs2_val,
                                bus.AGEX_latch_out.aluout, p);
            end
        end
    endtask

    // Reset in the middle of a multiply abandons it
    task automatic test_mul_reset();
        de_latch_t a;
        int        seen;
        step(mk(OP_MUL, 32'h700, 32'd1234, 32'd5678, 32'd0, 5'd9), 1'b0);
        for (int c = 1; c <= 9; c++) step('0, 1'b0);
        step('0, 1'b1);
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out !== '0 || bus.from_AGEX_to_DE.agex_busy !== 1'b0) begin
            bad++; $display("FAIL mul_reset got latch=%h busy=%b want 0/0", bus.AGEX_latch_out,
                            bus.from_AGEX_to_DE.agex_busy);
        end
        seen = 0;
        for (int c = 12; c <= 45; c++) begin
            step('0, 1'b0);
            if (bus.AGEX_latch_out !== '0 || bus.from_AGEX_to_DE.agex_busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mul_abandoned got=%0d non-idle cycles want=0", seen);
        end
        a = mk(OP_ADD, 32'h710, 32'd40, 32'd2, 32'd0, 5'd11);
        step(a, 1'b0);
        step('0, 1'b0);
        total++;
        if (bus.AGEX_latch_out.aluout !== 32'd42 || bus.AGEX_latch_out.rd !== 5'd11) begin
            bad++; $display("FAIL add_after_reset got alu=%h rd=%0d want 0000002a/11",
                            bus.AGEX_latch_out.aluout, bus.AGEX_latch_out.rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.from_DE_latch = '0;
        test_reset();
        test_add();
        test_branch();
        test_jalr();
        test_sw();
        test_random_ops();
        test_mul();
        test_mul_random();
        test_mul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
